// File: rtl/bsg_manycore_pkt_encode_buffered_pkg.sv
// rtl/bsg_manycore_pkt_encode_buffered_pkg.sv - op encodings and width helpers for the buffered packet encoder
package bsg_manycore_pkt_encode_buffered_pkg;

    typedef enum logic [1:0] {
        e_op_load  = 2'd0,
        e_op_store = 2'd1,
        e_op_cfg   = 2'd2
    } op_e;

    // Packet layout, MSB first: addr, op, op_ex, data, from_y, from_x, y_cord, x_cord.
    function automatic int packet_width(int addr_w, int data_w, int x_w, int y_w);
        return addr_w + 2 + data_w / 8 + data_w + 2 * x_w + 2 * y_w;
    endfunction

    // Core address: remote, y, x, then the local address with one extra MSB selecting cfg space.
    function automatic int core_addr_width(int addr_w, int x_w, int y_w);
        return 1 + y_w + x_w + addr_w + 1;
    endfunction

endpackage

// File: rtl/bsg_manycore_pkt_encode_buffered_if.sv
// rtl/bsg_manycore_pkt_encode_buffered_if.sv - core request and network link signals of the encoder
interface bsg_manycore_pkt_encode_buffered_if #(
    parameter int x_cord_width_p    = 4,
    parameter int y_cord_width_p    = 3,
    parameter int data_width_p      = 32,
    parameter int addr_width_p      = 12,
    parameter int max_out_credits_p = 16
);
    import bsg_manycore_pkt_encode_buffered_pkg::*;

    localparam int core_addr_width_lp = core_addr_width(addr_width_p, x_cord_width_p, y_cord_width_p);
    localparam int packet_width_lp    = packet_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p);
    localparam int credit_width_lp    = $clog2(max_out_credits_p + 1);

    logic                          req_v;
    logic                          req_ready;
    logic [core_addr_width_lp-1:0] req_addr;
    logic [data_width_p-1:0]       req_data;
    logic [data_width_p/8-1:0]     req_mask;
    logic                          req_we;
    logic [x_cord_width_p-1:0]     my_x;
    logic [y_cord_width_p-1:0]     my_y;
    logic                          local_v;
    logic                          pkt_v;
    logic [packet_width_lp-1:0]    pkt_data;
    logic                          pkt_ready;
    logic                          credit_return;
    logic [credit_width_lp-1:0]    out_credits;
    logic                          idle;

    modport master (
        output req_v, req_addr, req_data, req_mask, req_we, my_x, my_y, pkt_ready, credit_return,
        input  req_ready, local_v, pkt_v, pkt_data, out_credits, idle
    );

    modport slave (
        input  req_v, req_addr, req_data, req_mask, req_we, my_x, my_y, pkt_ready, credit_return,
        output req_ready, local_v, pkt_v, pkt_data, out_credits, idle
    );

endinterface

// File: rtl/bsg_manycore_pkt_encode_buffered_fifo.sv
// rtl/bsg_manycore_pkt_encode_buffered_fifo.sv - small 1r1w FIFO with registered full/empty flags
module bsg_manycore_pkt_encode_buffered_fifo #(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_v,
    output logic               enq_ready,
    input  logic [width_p-1:0] enq_data,
    output logic               deq_v,
    output logic [width_p-1:0] deq_data,
    input  logic               deq_yumi
);
    localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;

    logic [width_p-1:0]      mem [els_p];
    logic [ptr_width_lp-1:0] wptr;
    logic [ptr_width_lp-1:0] rptr;
    logic                    full;
    logic                    empty;
    logic                    enq;
    logic                    deq;

    function automatic logic [ptr_width_lp-1:0] ptr_next(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + ptr_width_lp'(1);
    endfunction

    assign enq       = enq_v & ~full;
    assign deq       = deq_yumi & ~empty;
    assign enq_ready = ~full;
    assign deq_v     = ~empty;
    assign deq_data  = mem[rptr];

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wptr] <= enq_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (enq) begin
                wptr <= ptr_next(wptr);
            end
            if (deq) begin
                rptr <= ptr_next(rptr);
            end
            if (enq && !deq) begin
                empty <= 1'b0;
                full  <= (ptr_next(wptr) == rptr);
            end else if (deq && !enq) begin
                full  <= 1'b0;
                empty <= (ptr_next(rptr) == wptr);
            end
        end
    end

endmodule

// File: rtl/bsg_manycore_pkt_encode_buffered.sv
// rtl/bsg_manycore_pkt_encode_buffered.sv - encodes remote core requests into buffered, credit-gated network packets
module bsg_manycore_pkt_encode_buffered
    import bsg_manycore_pkt_encode_buffered_pkg::*;
#(
    parameter int x_cord_width_p    = 4,
    parameter int y_cord_width_p    = 3,
    parameter int data_width_p      = 32,
    parameter int addr_width_p      = 12,
    parameter int fifo_els_p        = 2,
    parameter int max_out_credits_p = 16
) (
    input logic clk,
    input logic reset,
    bsg_manycore_pkt_encode_buffered_if.slave bus
);
    localparam int packet_width_lp = packet_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p);
    localparam int credit_width_lp = $clog2(max_out_credits_p + 1);
    localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

    typedef struct packed {
        logic                      remote;
        logic [y_cord_width_p-1:0] y;
        logic [x_cord_width_p-1:0] x;
        logic [addr_width_p:0]     addr;
    } addr_decode_s;

    typedef struct packed {
        logic [addr_width_p-1:0]   addr;
        logic [1:0]                op;
        logic [data_width_p/8-1:0] op_ex;
        logic [data_width_p-1:0]   data;
        logic [y_cord_width_p-1:0] from_y;
        logic [x_cord_width_p-1:0] from_x;
        logic [y_cord_width_p-1:0] y_cord;
        logic [x_cord_width_p-1:0] x_cord;
    } packet_s;

    addr_decode_s               addr_dec;
    packet_s                    pkt_in;
    logic                       enq;
    logic                       enq_ready;
    logic                       fifo_v;
    logic [packet_width_lp-1:0] fifo_data;
    logic                       deq;
    logic [credit_width_lp-1:0] credits;

    assign addr_dec = bus.req_addr;

    always_comb begin
        pkt_in        = '0;
        pkt_in.addr   = addr_dec.addr[addr_width_p-1:0];
        pkt_in.op     = bus.req_we ? (addr_dec.addr[addr_width_p] ? e_op_cfg : e_op_store) : e_op_load;
        pkt_in.op_ex  = bus.req_mask;
        pkt_in.data   = bus.req_we ? bus.req_data : '0;
        pkt_in.from_y = bus.my_y;
        pkt_in.from_x = bus.my_x;
        pkt_in.y_cord = addr_dec.y;
        pkt_in.x_cord = addr_dec.x;
    end

    // Readiness depends only on the address and the registered full flag, never on req_v.
    assign bus.req_ready = addr_dec.remote ? enq_ready : 1'b1;
    assign bus.local_v   = bus.req_v & ~addr_dec.remote;
    assign enq           = bus.req_v & addr_dec.remote & enq_ready;

    bsg_manycore_pkt_encode_buffered_fifo #(
        .width_p (packet_width_lp),
        .els_p   (fifo_els_p)
    ) fifo (
        .clk       (clk),
        .reset     (reset),
        .enq_v     (enq),
        .enq_ready (enq_ready),
        .enq_data  (pkt_in),
        .deq_v     (fifo_v),
        .deq_data  (fifo_data),
        .deq_yumi  (deq)
    );

    // Credits only fall on dispatch, so a presented packet cannot be withdrawn.
    assign bus.pkt_v       = fifo_v & (credits != '0);
    assign bus.pkt_data    = fifo_data;
    assign deq             = bus.pkt_v & bus.pkt_ready;
    assign bus.out_credits = credits;
    assign bus.idle        = ~fifo_v & (credits == max_credits_lp);

    always_ff @(posedge clk) begin
        if (reset) begin
            credits <= max_credits_lp;
        end else if (deq && !bus.credit_return) begin
            credits <= credits - credit_width_lp'(1);
        end else if (!deq && bus.credit_return && credits != max_credits_lp) begin
            credits <= credits + credit_width_lp'(1);
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (bus.credit_return && !deq && credits == max_credits_lp) begin
                $error("credit returned while counter is already at maximum");
            end
            if (enq && bus.req_we && addr_dec.addr[1:0] != 2'b00) begin
                $error("unaligned remote store address");
            end
        end
    end
`endif

endmodule

// File: tb/tb_bsg_manycore_pkt_encode_buffered.sv
// tb/tb_bsg_manycore_pkt_encode_buffered.sv - directed self-checking bench for the buffered packet encoder
module tb_bsg_manycore_pkt_encode_buffered;

    localparam int XW = 4;
    localparam int YW = 3;
    localparam int DW = 32;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bsg_manycore_pkt_encode_buffered_if #(.x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW),
        .addr_width_p(AW), .max_out_credits_p(16)) a ();
    bsg_manycore_pkt_encode_buffered_if #(.x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW),
        .addr_width_p(AW), .max_out_credits_p(2)) b ();

    bsg_manycore_pkt_encode_buffered #(.x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW),
        .addr_width_p(AW), .fifo_els_p(2), .max_out_credits_p(16)) dut_a (
        .clk(clk), .reset(reset), .bus(a));

    bsg_manycore_pkt_encode_buffered #(.x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW),
        .addr_width_p(AW), .fifo_els_p(2), .max_out_credits_p(2)) dut_b (
        .clk(clk), .reset(reset), .bus(b));

    function automatic logic [63:0] pk(input logic [11:0] ad, input logic [1:0] op, input logic [3:0] m,
                                       input logic [31:0] d, input logic [2:0] fy, input logic [3:0] fx,
                                       input logic [2:0] y, input logic [3:0] x);
        return {ad, op, m, d, fy, fx, y, x};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic r, input logic [2:0] y, input logic [3:0] x,
                         input logic [12:0] ad, input logic [31:0] d, input logic [3:0] m, input logic we);
        a.req_v = v; a.req_addr = {r, y, x, ad}; a.req_data = d; a.req_mask = m; a.req_we = we;
    endtask

    task automatic set_b(input logic v, input logic [12:0] ad, input logic [31:0] d);
        b.req_v = v; b.req_addr = {1'b1, 3'd2, 4'd3, ad}; b.req_data = d; b.req_mask = 4'hF; b.req_we = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        set_a(0, 0, 0, 0, 0, 0, 0, 0);
        set_b(0, 0, 0);
        a.my_x = 4'd5; a.my_y = 3'd3; a.pkt_ready = 0; a.credit_return = 0;
        b.my_x = 4'd1; b.my_y = 3'd6; b.pkt_ready = 0; b.credit_return = 0;
        step; step;
        reset = 1'b0;
        #1;
        checks++; if (a.pkt_v !== 1'b0) begin errors++; $display("FAIL reset_v got %0b want 0", a.pkt_v); end
        checks++; if (a.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", a.req_ready); end
        checks++; if (a.idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %0b want 1", a.idle); end
        checks++; if (a.out_credits !== 5'd16) begin errors++; $display("FAIL reset_credits got %0d want 16", a.out_credits); end
        checks++; if (b.out_credits !== 2'd2) begin errors++; $display("FAIL reset_credits_b got %0d want 2", b.out_credits); end
    endtask

    task automatic test_single_store;
        set_a(1, 1, 3'd1, 4'd2, 13'h040, 32'hDEADBEEF, 4'hF, 1);
        #1;
        checks++; if (a.req_ready !== 1'b1) begin errors++; $display("FAIL store_ready got %0b want 1", a.req_ready); end
        checks++; if (a.local_v !== 1'b0) begin errors++; $display("FAIL store_local got %0b want 0", a.local_v); end
        checks++; if (a.pkt_v !== 1'b0) begin errors++; $display("FAIL store_latency got %0b want 0", a.pkt_v); end
        step;
        a.req_v = 0;
        #1;
        checks++; if (a.pkt_v !== 1'b1) begin errors++; $display("FAIL store_v got %0b want 1", a.pkt_v); end
        checks++; if (a.pkt_data !== pk(12'h040, 2'b01, 4'hF, 32'hDEADBEEF, 3'd3, 4'd5, 3'd1, 4'd2)) begin
            errors++; $display("FAIL store_pkt got %h", a.pkt_data); end
        a.pkt_ready = 1;
        step;
        a.pkt_ready = 0;
        #1;
        checks++; if (a.out_credits !== 5'd15) begin errors++; $display("FAIL store_credits got %0d want 15", a.out_credits); end
        checks++; if (a.idle !== 1'b0) begin errors++; $display("FAIL store_idle got %0b want 0", a.idle); end
        a.credit_return = 1;
        step;
        a.credit_return = 0;
        #1;
        checks++; if (a.out_credits !== 5'd16) begin errors++; $display("FAIL store_return got %0d want 16", a.out_credits); end
    endtask

    task automatic test_load;
        set_a(1, 1, 3'd2, 4'd3, 13'h080, 32'h12345678, 4'h3, 0);
        step;
        a.req_v = 0;
        #1;
        checks++; if (a.pkt_data !== pk(12'h080, 2'b00, 4'h3, 32'h0, 3'd3, 4'd5, 3'd2, 4'd3)) begin
            errors++; $display("FAIL load_pkt got %h", a.pkt_data); end
        a.pkt_ready = 1;
        step;
        a.pkt_ready = 0;
        #1;
        checks++; if (a.out_credits !== 5'd15) begin errors++; $display("FAIL load_credits got %0d want 15", a.out_credits); end
        a.credit_return = 1;
        step;
        a.credit_return = 0;
        #1;
        checks++; if (a.idle !== 1'b1) begin errors++; $display("FAIL load_idle got %0b want 1", a.idle); end
    endtask

    task automatic test_cfg_store;
        set_a(1, 1, 3'd0, 4'd1, 13'h1008, 32'hA5A50F0F, 4'h5, 1);
        step;
        a.req_v = 0;
        #1;
        checks++; if (a.pkt_data !== pk(12'h008, 2'b10, 4'h5, 32'hA5A50F0F, 3'd3, 4'd5, 3'd0, 4'd1)) begin
            errors++; $display("FAIL cfg_pkt got %h", a.pkt_data); end
        a.pkt_ready = 1;
        step;
        a.pkt_ready = 0;
        a.credit_return = 1;
        step;
        a.credit_return = 0;
        #1;
        checks++; if (a.idle !== 1'b1) begin errors++; $display("FAIL cfg_idle got %0b want 1", a.idle); end
    endtask

    task automatic test_fifo_full;
        a.pkt_ready = 0;
        for (int i = 0; i < 4; i++) begin
            set_a(1, 1, 3'd1, 4'd1, 13'(16 + 4 * i), 32'hC0DE0000 + 32'(i), 4'hF, 1);
            #1;
            checks++; if (a.req_ready !== (i < 2)) begin
                errors++; $display("FAIL full_ready_%0d got %0b want %0b", i, a.req_ready, (i < 2)); end
            if (i > 0) begin
                checks++; if (a.pkt_data !== pk(12'h010, 2'b01, 4'hF, 32'hC0DE0000, 3'd3, 4'd5, 3'd1, 4'd1)) begin
                    errors++; $display("FAIL full_stable_%0d got %h", i, a.pkt_data); end
            end
            step;
        end
        a.req_v = 0;
        a.pkt_ready = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (a.pkt_v !== 1'b1) begin errors++; $display("FAIL drain_v_%0d got %0b want 1", i, a.pkt_v); end
            checks++; if (a.pkt_data !== pk(12'(16 + 4 * i), 2'b01, 4'hF, 32'hC0DE0000 + 32'(i), 3'd3, 4'd5, 3'd1, 4'd1)) begin
                errors++; $display("FAIL drain_order_%0d got %h", i, a.pkt_data); end
            step;
        end
        a.pkt_ready = 0;
        #1;
        checks++; if (a.pkt_v !== 1'b0) begin errors++; $display("FAIL drain_empty got %0b want 0", a.pkt_v); end
        checks++; if (a.out_credits !== 5'd14) begin errors++; $display("FAIL drain_credits got %0d want 14", a.out_credits); end
        a.credit_return = 1;
        step; step;
        a.credit_return = 0;
        #1;
        checks++; if (a.out_credits !== 5'd16) begin errors++; $display("FAIL drain_return got %0d want 16", a.out_credits); end
    endtask

    task automatic test_credit_limit;
        b.pkt_ready = 1;
        for (int i = 0; i < 3; i++) begin
            set_b(1, 13'(32 + 4 * i), 32'hB0000000 + 32'(i));
            #1;
            checks++; if (b.req_ready !== 1'b1) begin errors++; $display("FAIL cred_ready_%0d got %0b want 1", i, b.req_ready); end
            step;
        end
        b.req_v = 0;
        #1;
        checks++; if (b.out_credits !== 2'd0) begin errors++; $display("FAIL cred_zero got %0d want 0", b.out_credits); end
        checks++; if (b.pkt_v !== 1'b0) begin errors++; $display("FAIL cred_hold got %0b want 0", b.pkt_v); end
        step;
        b.credit_return = 1;
        #1;
        checks++; if (b.pkt_v !== 1'b0) begin errors++; $display("FAIL cred_hold2 got %0b want 0", b.pkt_v); end
        step;
        b.credit_return = 0;
        #1;
        checks++; if (b.pkt_v !== 1'b1) begin errors++; $display("FAIL cred_release got %0b want 1", b.pkt_v); end
        checks++; if (b.pkt_data !== pk(12'h028, 2'b01, 4'hF, 32'hB0000002, 3'd6, 4'd1, 3'd2, 4'd3)) begin
            errors++; $display("FAIL cred_pkt got %h", b.pkt_data); end
        step;
        b.pkt_ready = 0;
        #1;
        checks++; if (b.out_credits !== 2'd0) begin errors++; $display("FAIL cred_after got %0d want 0", b.out_credits); end
        b.credit_return = 1;
        step; step;
        b.credit_return = 0;
        #1;
        checks++; if (b.idle !== 1'b1) begin errors++; $display("FAIL cred_idle got %0b want 1", b.idle); end
    endtask

    task automatic test_local;
        set_a(1, 0, 3'd1, 4'd2, 13'h040, 32'h55AA55AA, 4'hF, 1);
        #1;
        checks++; if (a.local_v !== 1'b1) begin errors++; $display("FAIL local_v got %0b want 1", a.local_v); end
        checks++; if (a.req_ready !== 1'b1) begin errors++; $display("FAIL local_ready got %0b want 1", a.req_ready); end
        step;
        a.req_v = 0;
        #1;
        checks++; if (a.pkt_v !== 1'b0) begin errors++; $display("FAIL local_pkt_v got %0b want 0", a.pkt_v); end
        checks++; if (a.idle !== 1'b1) begin errors++; $display("FAIL local_idle got %0b want 1", a.idle); end
    endtask

    task automatic test_reset_mid;
        a.pkt_ready = 1;
        for (int i = 0; i < 5; i++) begin
            set_a(1, 1, 3'd1, 4'd2, 13'(64 + 4 * i), 32'hE0000000 + 32'(i), 4'hF, 1);
            if (i == 4) a.pkt_ready = 0;
            step;
        end
        a.req_v = 0;
        #1;
        checks++; if (a.out_credits !== 5'd13) begin errors++; $display("FAIL mid_credits got %0d want 13", a.out_credits); end
        checks++; if (a.req_ready !== 1'b0) begin errors++; $display("FAIL mid_full got %0b want 0", a.req_ready); end
        reset = 1'b1;
        step;
        reset = 1'b0;
        #1;
        checks++; if (a.pkt_v !== 1'b0) begin errors++; $display("FAIL mid_v got %0b want 0", a.pkt_v); end
        checks++; if (a.out_credits !== 5'd16) begin errors++; $display("FAIL mid_restore got %0d want 16", a.out_credits); end
        checks++; if (a.idle !== 1'b1) begin errors++; $display("FAIL mid_idle got %0b want 1", a.idle); end
    endtask

    task automatic test_back_to_back;
        set_a(1, 1, 3'd1, 4'd2, 13'h100, 32'h11111111, 4'hF, 1);
        step;
        a.req_v = 0;
        a.pkt_ready = 1;
        step;
        a.pkt_ready = 0;
        set_a(1, 1, 3'd1, 4'd2, 13'h104, 32'h22222222, 4'hF, 1);
        #1;
        checks++; if (a.out_credits !== 5'd15) begin errors++; $display("FAIL b2b_first got %0d want 15", a.out_credits); end
        step;
        a.req_v = 0;
        a.pkt_ready = 1;
        a.credit_return = 1;
        step;
        a.pkt_ready = 0;
        a.credit_return = 0;
        #1;
        checks++; if (a.out_credits !== 5'd15) begin errors++; $display("FAIL b2b_same got %0d want 15", a.out_credits); end
        checks++; if (a.pkt_v !== 1'b0) begin errors++; $display("FAIL b2b_v got %0b want 0", a.pkt_v); end
        a.credit_return = 1;
        step;
        a.credit_return = 0;
        #1;
        checks++; if (a.idle !== 1'b1) begin errors++; $display("FAIL b2b_idle got %0b want 1", a.idle); end
    endtask

    initial begin
        test_reset;
        test_single_store;
        test_load;
        test_cfg_store;
        test_fifo_full;
        test_credit_limit;
        test_local;
        test_reset_mid;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
